// File: rtl/motion_door_timer.sv
// Door / travel interval timer for the elevator controller.
// Times the held-high opendoor and mv2nxt commands and answers with one-cycle completion pulses.
module motion_door_timer #(
  parameter int DOOR_TICKS = 96,
  parameter int RUN_TICKS  = 64,
  parameter int DOOR_MIN   = 16,
  parameter int MAX_EXTEND = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       switch,
  input  logic       opendoor,
  input  logic       mv2nxt,
  input  logic       open_btn,
  input  logic       close_btn,
  output logic       endOpen,
  output logic       endRun,
  output logic [6:0] DoorCount,
  output logic [6:0] RunCount,
  output logic       conflict
);

  typedef enum logic [2:0] {IDLE, DOOR, RUN, DONE_DOOR, DONE_RUN} state_t;

  localparam logic [6:0] DOOR_LAST = 7'(DOOR_TICKS - 1);
  localparam logic [6:0] RUN_LAST  = 7'(RUN_TICKS - 1);
  localparam logic [6:0] DOOR_MINC = 7'(DOOR_MIN);
  localparam logic [1:0] EXT_MAX   = 2'(MAX_EXTEND);

  state_t     state_q, state_d;
  logic [6:0] door_cnt_q, door_cnt_d;
  logic [6:0] run_cnt_q, run_cnt_d;
  logic [1:0] ext_q, ext_d;
  logic       end_open_q, end_open_d;
  logic       end_run_q, end_run_d;
  logic       conflict_q, conflict_d;
  logic       take_cmd;

  always_comb begin
    state_d    = state_q;
    door_cnt_d = door_cnt_q;
    run_cnt_d  = run_cnt_q;
    ext_d      = ext_q;
    end_open_d = 1'b0;
    end_run_d  = 1'b0;
    conflict_d = 1'b0;
    take_cmd   = 1'b0;

    case (state_q)
      IDLE: take_cmd = 1'b1;
      DOOR: begin
        if (!opendoor) begin
          state_d    = IDLE;
          door_cnt_d = '0;
        end else if (open_btn && (ext_q < EXT_MAX)) begin
          door_cnt_d = '0;
          ext_d      = ext_q + 2'd1;
        // Already at the last tick: a held close button must not stall completion.
        end else if (close_btn && (door_cnt_q >= DOOR_MINC) && (door_cnt_q != DOOR_LAST)) begin
          door_cnt_d = DOOR_LAST;
        end else if (door_cnt_q == DOOR_LAST) begin
          end_open_d = 1'b1;
          state_d    = DONE_DOOR;
        end else begin
          door_cnt_d = door_cnt_q + 7'd1;
        end
      end
      RUN: begin
        conflict_d = opendoor;
        if (!mv2nxt) begin
          state_d   = IDLE;
          run_cnt_d = '0;
        end else if (run_cnt_q == RUN_LAST) begin
          end_run_d = 1'b1;
          state_d   = DONE_RUN;
        end else begin
          run_cnt_d = run_cnt_q + 7'd1;
        end
      end
      DONE_DOOR: begin
        if (!opendoor) begin
          state_d    = IDLE;
          door_cnt_d = '0;
          take_cmd   = 1'b1;
        end
      end
      DONE_RUN: begin
        if (!mv2nxt) begin
          state_d   = IDLE;
          run_cnt_d = '0;
          take_cmd  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Command acceptance is shared so a DONE state hands over to the next command without an idle cycle.
    if (take_cmd) begin
      if (opendoor) begin
        state_d    = DOOR;
        door_cnt_d = '0;
        ext_d      = '0;
      end else if (mv2nxt) begin
        state_d   = RUN;
        run_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !switch) begin
      state_q    <= IDLE;
      door_cnt_q <= '0;
      run_cnt_q  <= '0;
      ext_q      <= '0;
      end_open_q <= 1'b0;
      end_run_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      door_cnt_q <= door_cnt_d;
      run_cnt_q  <= run_cnt_d;
      ext_q      <= ext_d;
      end_open_q <= end_open_d;
      end_run_q  <= end_run_d;
      conflict_q <= conflict_d;
    end
  end

  assign endOpen   = end_open_q;
  assign endRun    = end_run_q;
  assign DoorCount = door_cnt_q;
  assign RunCount  = run_cnt_q;
  assign conflict  = conflict_q;

endmodule

// File: tb/tb_motion_door_timer.sv
// Scenario bench for motion_door_timer: expected latencies are queued when a command is
// issued and popped when the completion pulse appears.
module tb_motion_door_timer;

  logic       clk = 1'b0;
  logic       rst, switch, opendoor, mv2nxt, open_btn, close_btn;
  logic       endOpen, endRun, conflict;
  logic [6:0] DoorCount, RunCount;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  motion_door_timer dut (
    .clk(clk), .rst(rst), .switch(switch), .opendoor(opendoor), .mv2nxt(mv2nxt),
    .open_btn(open_btn), .close_btn(close_btn), .endOpen(endOpen), .endRun(endRun),
    .DoorCount(DoorCount), .RunCount(RunCount), .conflict(conflict)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; switch = 1'b1; opendoor = 1'b0; mv2nxt = 1'b0;
    open_btn = 1'b0; close_btn = 1'b0;
    step(); step();
    checks++;
    if ({endOpen, endRun, conflict, DoorCount, RunCount} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", {endOpen, endRun, conflict, DoorCount, RunCount});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({endOpen, endRun, DoorCount, RunCount} !== 16'd0) begin
      errors++;
      $display("FAIL idle_quiet got=%h want=0", {endOpen, endRun, DoorCount, RunCount});
    end
  endtask

  // Door held from E0, then the opendoor-fall / mv2nxt-rise handover into travel.
  task automatic test_door_then_run();
    int lat, exp;
    opendoor = 1'b1;
    step();
    exp_q.push_back(96);
    checks++;
    if (DoorCount !== 7'd0) begin errors++; $display("FAIL door_start got=%0d want=0", DoorCount); end
    lat = 0;
    while (!endOpen && lat < 400) begin step(); lat++; end
    exp = exp_q.pop_front();
    checks++;
    if (lat !== exp) begin errors++; $display("FAIL door_latency got=%0d want=%0d", lat, exp); end
    checks++;
    if (DoorCount !== 7'd95) begin errors++; $display("FAIL door_final got=%0d want=95", DoorCount); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (endOpen !== 1'b0 || DoorCount !== 7'd95) begin
        errors++;
        $display("FAIL door_hold endOpen=%b cnt=%0d want endOpen=0 cnt=95", endOpen, DoorCount);
      end
    end
    opendoor = 1'b0; mv2nxt = 1'b1;
    step();
    exp_q.push_back(64);
    checks++;
    if (DoorCount !== 7'd0 || RunCount !== 7'd0) begin
      errors++;
      $display("FAIL handover door=%0d run=%0d want 0 0", DoorCount, RunCount);
    end
    step();
    checks++;
    if (RunCount !== 7'd1) begin errors++; $display("FAIL handover_run got=%0d want=1", RunCount); end
    lat = 1;
    while (!endRun && lat < 400) begin step(); lat++; end
    exp = exp_q.pop_front();
    checks++;
    if (lat !== exp) begin errors++; $display("FAIL run_latency got=%0d want=%0d", lat, exp); end
    step();
    checks++;
    if (endRun !== 1'b0 || RunCount !== 7'd63) begin
      errors++;
      $display("FAIL run_pulse_width endRun=%b cnt=%0d want 0 63", endRun, RunCount);
    end
    mv2nxt = 1'b0;
    step();
    checks++;
    if (RunCount !== 7'd0) begin errors++; $display("FAIL run_release got=%0d want=0", RunCount); end
  endtask

  // Presses sampled while DoorCount reads 49 replace the step to 50, so each honoured restart
  // costs 50 cycles: 96 + 3*50 = 246.
  task automatic test_extend();
    int lat, exp, presses, after4;
    presses = 0; after4 = -1;
    opendoor = 1'b1;
    step();
    exp_q.push_back(246);
    lat = 0;
    while (!endOpen && lat < 600) begin
      open_btn = (DoorCount == 7'd49) && (presses < 4);
      if (open_btn) presses++;
      step(); lat++;
      if (open_btn && presses == 4) after4 = DoorCount;
      open_btn = 1'b0;
    end
    exp = exp_q.pop_front();
    checks++;
    if (lat !== exp) begin errors++; $display("FAIL extend_latency got=%0d want=%0d", lat, exp); end
    checks++;
    if (after4 !== 50) begin errors++; $display("FAIL extend_fourth got=%0d want=50", after4); end
    opendoor = 1'b0;
    step();
  endtask

  task automatic test_close();
    opendoor = 1'b1;
    step();
    for (int i = 0; i < 50 && DoorCount !== 7'd10; i++) step();
    close_btn = 1'b1; step(); close_btn = 1'b0;
    checks++;
    if (DoorCount !== 7'd11) begin errors++; $display("FAIL close_early got=%0d want=11", DoorCount); end
    for (int i = 0; i < 50 && DoorCount !== 7'd20; i++) step();
    close_btn = 1'b1; step(); close_btn = 1'b0;
    checks++;
    if (DoorCount !== 7'd95 || endOpen !== 1'b0) begin
      errors++;
      $display("FAIL close_jump cnt=%0d endOpen=%b want 95 0", DoorCount, endOpen);
    end
    step();
    checks++;
    if (endOpen !== 1'b1) begin errors++; $display("FAIL close_end got=%b want=1", endOpen); end
    opendoor = 1'b0;
    step();
  endtask

  task automatic test_conflict();
    int lat, exp, pulses;
    mv2nxt = 1'b1;
    step();
    exp_q.push_back(64);
    lat = 0; pulses = 0;
    while (!endRun && lat < 400) begin
      opendoor = (RunCount == 7'd30);
      step(); lat++;
      if (conflict) pulses++;
      opendoor = 1'b0;
    end
    exp = exp_q.pop_front();
    checks++;
    if (lat !== exp) begin errors++; $display("FAIL conflict_run_latency got=%0d want=%0d", lat, exp); end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL conflict_pulses got=%0d want=1", pulses); end
    mv2nxt = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_run(input bit use_switch);
    mv2nxt = 1'b1;
    step();
    for (int i = 0; i < 100 && RunCount !== 7'd40; i++) step();
    if (use_switch) switch = 1'b0; else rst = 1'b1;
    step();
    checks++;
    if ({endOpen, endRun, conflict, DoorCount, RunCount} !== 17'd0) begin
      errors++;
      $display("FAIL midrun_reset sw=%0d got=%h want=0", use_switch, {endOpen, endRun, conflict, DoorCount, RunCount});
    end
    switch = 1'b1; rst = 1'b0;
    step();
    step();
    checks++;
    if (RunCount !== 7'd1) begin errors++; $display("FAIL midrun_restart sw=%0d got=%0d want=1", use_switch, RunCount); end
    mv2nxt = 1'b0;
    step();
  endtask

  task automatic test_priority_and_drop();
    opendoor = 1'b1; mv2nxt = 1'b1;
    step(); step(); step();
    checks++;
    if (DoorCount !== 7'd2 || RunCount !== 7'd0) begin
      errors++;
      $display("FAIL door_priority door=%0d run=%0d want 2 0", DoorCount, RunCount);
    end
    opendoor = 1'b0; mv2nxt = 1'b0;
    step();
    checks++;
    if (DoorCount !== 7'd0 || endOpen !== 1'b0) begin
      errors++;
      $display("FAIL door_drop cnt=%0d endOpen=%b want 0 0", DoorCount, endOpen);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_door_then_run();
    test_extend();
    test_close();
    test_conflict();
    test_reset_mid_run(1'b0);
    test_reset_mid_run(1'b1);
    test_priority_and_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
